// File: rtl/bitserial_logic_unit.sv
// Bit-serial bitwise-logic unit.
// Takes an operand pair and an op code over a valid/ready request channel,
// evaluates the selected logic function one bit per cycle (LSB first) by
// shifting the operands right and the result in from the MSB side, then
// presents the full word on a valid/ready response channel.
// Handshake outputs are decoded from the registered state only, so there is
// no combinational path from any input to any output.
module bitserial_logic_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] op_count
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic [1:0]       op_q,       op_d;
    logic [WIDTH-1:0] res_q,      res_d;
    logic [BIT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    // Single-bit logic function selected by the latched op code.
    function automatic logic logic_bit(input logic [1:0] f, input logic x, input logic y);
        case (f)
            OP_AND:  logic_bit = x & y;
            OP_OR:   logic_bit = x | y;
            OP_XOR:  logic_bit = x ^ y;
            default: logic_bit = ~(x | y);
        endcase
    endfunction

    // Next-state: accept in IDLE, one bit per cycle in BUSY, hold until taken in DONE.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_d      = res_q;
        bit_cnt_d  = bit_cnt_q;
        op_count_d = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    op_d      = op;
                    bit_cnt_d = '0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                // The bit computed first ends up at position 0 after WIDTH shifts.
                res_d     = {logic_bit(op_q, a_q[0], b_q[0]), res_q[WIDTH-1:1]};
                a_d       = a_q >> 1;
                b_d       = b_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d    = S_IDLE;
                    op_count_d = op_count_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            bit_cnt_q  <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            bit_cnt_q  <= bit_cnt_d;
            op_count_q <= op_count_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign op_count  = op_count_q;

endmodule

// File: doc/bitserial_logic_unit.md
Name: bitserial_logic_unit

Overview:
- Sequential responder for the bitwise-logic operand/result interface.
- Accepts one operand pair plus an op code through a valid/ready request channel.
- Computes the result one bit per cycle, LSB first, through shift registers.
- Returns the result on a valid/ready response channel; upstream benches and sequencers act as the initiator.

Parameters:
- WIDTH, 4: operand and result width in bits; legal range 2..32.
- CNT_W, 8: width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- op  input  2  sampled on accept: 00 AND, 01 OR, 10 XOR, 11 NOR
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  computed result
- op_count  output  CNT_W  number of completed handshakes

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, in_ready=1, out_valid=0, result=0, op_count=0.
  - Internal shift registers, op latch and bit counter cleared.
  - A reset mid-operation abandons the operation; no partial result is ever presented.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&&in_ready at a rising edge: latch a, b, op; bit counter=0; go to BUSY.
- BUSY:
  - in_ready=0; in_valid and operand changes are ignored.
  - Each edge computes bit[0] of the A/B shift registers with the latched op, shifts it into the result register from the MSB side, shifts A/B right by one, and increments the counter.
  - After the edge that processes bit WIDTH-1, go to DONE.
- DONE:
  - out_valid=1; result holds the full WIDTH-bit value, with bit i = f(a[i], b[i]).
  - result is stable while out_valid=1 and out_ready=0; backpressure can be held indefinitely.
  - On out_valid&&out_ready at an edge: go to IDLE, out_valid=0, op_count increments.
- Counter rules:
  - op_count increments modulo 2^CNT_W; 255 + 1 = 0 at CNT_W=8.
  - It counts completed response handshakes only.
- Latency:
  - Request accepted at edge E gives out_valid=1 after edge E+WIDTH.
  - in_ready returns to 1 after the response handshake edge.
  - Minimum request spacing is WIDTH+2 cycles with out_ready held at 1.
- Result register:
  - result retains its last value in IDLE.
  - It is overwritten progressively during BUSY, so consumers use it only when out_valid=1.
- No request and response handshake occurs on the same edge, because in_ready and out_valid are mutually exclusive.
- The outputs in_ready and out_valid are driven purely from state (registered); there is no combinational path from any input to any output.

Test Plan:
- OR, a=1001, b=0101, out_ready=1: out_valid after 4 edges, result=1101; then a=0011, b=1100 gives result=1111; op_count=2.
- AND a=1001, b=0101 gives 0001; XOR a=0110, b=0101 gives 0011; NOR a=0000, b=0000 gives 1111. Each takes exactly 4 BUSY cycles.
- Backpressure: out_ready=0 for 5 cycles after out_valid → result and out_valid stay constant and in_ready stays 0. Raising out_ready gives IDLE on the next edge and op_count+1.
- Busy protection: in_valid=1 with a=1111, b=1111 held throughout BUSY and DONE. The first accepted request's result is unchanged, and the second request is accepted only in the cycle after the response handshake.
- Reset mid-op: assert rst two cycles into BUSY → out_valid=0, in_ready=1, result=0 and op_count=0 immediately (asynchronously). The next request completes normally.
- Wrap: complete 256 OR operations with CNT_W=8 → op_count reads 0 after the 256th handshake.
